// File: rtl/spi_slave_regs.sv
// SPI responder backing an 8-bit register file: command byte (R/W + 7-bit address)
// followed by auto-incrementing burst data, with all SPI pins oversampled on clk.
module spi_slave_regs #(
  parameter int N_REGS = 16,
  parameter bit CPOL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                n_cs,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic [8*N_REGS-1:0] regs_bus,
  output logic [N_REGS-1:0]   wr_strobe,
  output logic                busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_mosi_s1, r_mosi_s2, r_mosi_s3;
  logic r_lead, r_trail, r_cs_fall;
  logic [2:0] r_warm;
  logic r_armed;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_bit_cnt, w_bit_nxt;
  logic [6:0]          r_rx, w_rx_nxt;
  logic [7:0]          r_tx, w_tx_nxt;
  logic                r_rw, w_rw_nxt;
  logic [6:0]          r_addr, w_addr_nxt;
  logic                w_we;
  logic [7:0]          w_rx_shift;
  logic [7:0]          w_rd_cmd, w_rd_next;
  logic [8*N_REGS-1:0] r_regs;
  logic [N_REGS-1:0]   r_wr_strobe;
  logic                w_lead, w_trail;

  function automatic logic [7:0] rd_reg(input logic [6:0] a);
    rd_reg = 8'h00;
    for (int i = 0; i < N_REGS; i++) begin
      if (a == 7'(i)) rd_reg = r_regs[8*i +: 8];
    end
  endfunction

  assign w_lead  = (r_sclk_s2 != r_sclk_s3) && (r_sclk_s2 != CPOL);
  assign w_trail = (r_sclk_s2 != r_sclk_s3) && (r_sclk_s2 == CPOL);

  // Synchronisers and edge detection; r_lead/r_trail/r_cs_fall line up with r_cs_s3 and r_mosi_s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_sclk_s1 <= CPOL;
      r_sclk_s2 <= CPOL;
      r_sclk_s3 <= CPOL;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_mosi_s3 <= 1'b0;
      r_lead    <= 1'b0;
      r_trail   <= 1'b0;
      r_cs_fall <= 1'b0;
      r_warm    <= 3'b000;
      r_armed   <= 1'b0;
    end else begin
      r_cs_s1   <= n_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_mosi_s3 <= r_mosi_s2;
      r_lead    <= w_lead;
      r_trail   <= w_trail;
      r_cs_fall <= r_cs_s3 & ~r_cs_s2;
      r_warm    <= {r_warm[1:0], 1'b1};
      // A frame already running when rst drops is ignored until n_cs is really seen high.
      if (r_warm[2] && r_cs_s3) r_armed <= 1'b1;
    end
  end

  assign w_rx_shift = {r_rx, r_mosi_s3};
  assign w_rd_cmd   = rd_reg(w_rx_shift[6:0]);
  assign w_rd_next  = rd_reg(r_addr + 7'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_rx_nxt    = r_rx;
    w_tx_nxt    = r_tx;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_we        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bit_nxt = 3'd0;
        w_tx_nxt  = 8'h00;
        if (r_armed && r_cs_fall) begin
          w_state_nxt = ST_CMD;
          w_rx_nxt    = 7'd0;
        end
      end
      ST_CMD: begin
        if (r_lead) begin
          w_rx_nxt = w_rx_shift[6:0];
          if (r_bit_cnt == 3'd7) begin
            w_bit_nxt   = 3'd0;
            w_rw_nxt    = w_rx_shift[7];
            w_addr_nxt  = w_rx_shift[6:0];
            w_state_nxt = ST_DATA;
            if (w_rx_shift[7]) w_tx_nxt = w_rd_cmd;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      ST_DATA: begin
        if (r_lead) begin
          w_rx_nxt = w_rx_shift[6:0];
          if (r_bit_cnt == 3'd7) begin
            w_bit_nxt  = 3'd0;
            w_addr_nxt = r_addr + 7'd1;
            if (r_rw) w_tx_nxt = w_rd_next;
            else      w_we     = 1'b1;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end else if (r_trail && r_rw && (r_bit_cnt != 3'd0)) begin
          // The trailing edge right after a byte load must not shift, or the MSB is lost.
          w_tx_nxt = {r_tx[6:0], 1'b0};
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && r_cs_s3) begin
      w_state_nxt = ST_IDLE;
      w_bit_nxt   = 3'd0;
      w_tx_nxt    = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 8'h00;
      r_rw      <= 1'b0;
      r_addr    <= 7'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_rx      <= w_rx_nxt;
      r_tx      <= w_tx_nxt;
      r_rw      <= w_rw_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  // Unmapped addresses match no index, so those bytes are dropped without a strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs      <= '0;
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_we) begin
        for (int i = 0; i < N_REGS; i++) begin
          if (r_addr == 7'(i)) begin
            r_regs[8*i +: 8] <= w_rx_shift;
            r_wr_strobe[i]   <= 1'b1;
          end
        end
      end
    end
  end

  assign miso      = r_tx[7];
  assign regs_bus  = r_regs;
  assign wr_strobe = r_wr_strobe;
  assign busy      = ~r_cs_s3;

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
SPI responder (slave end) for the team's if_spi masters: a bench/loopback model and an on-FPGA register target.
- Oversamples sclk/n_cs/mosi on the system clock and decodes a command/address byte followed by burst data bytes.
- Backs an 8-bit register file, with per-register write strobes to fabric logic.
- Read data is shifted back on miso, so an if_spi master (CPOL 0 or 1) can write and read it over the same 4-wire link.

Parameters:
N_REGS, 16, number of 8-bit registers (1..128); addresses ≥ N_REGS are unmapped.
CPOL, 0, sclk idle level; 0 = sample on rising edge, 1 = sample on falling edge (leading edge always samples, trailing edge shifts).

Ports:
clk  in  1  system clock; sclk frequency ≤ clk/8.
rst  in  1  asynchronous, active-high reset.
n_cs  in  1  chip select, active low, asynchronous to clk.
sclk  in  1  SPI clock, asynchronous to clk.
mosi  in  1  master data, MSB first.
miso  out  1  slave data, MSB first; always driven, no tri-state.
regs_bus  out  8*N_REGS  register contents; reg i at [8*i+:8].
wr_strobe  out  N_REGS  one-clk pulse on the cycle reg i is written.
busy  out  1  high while n_cs (synchronised) is low.

Behaviour:
- Reset: clocks are single clk; reset is async active-high on rst. All regs = 0x00, wr_strobe = 0, busy = 0, miso = 0, FSM = IDLE, bit counter = 0.
- Synchronisers: n_cs, sclk and mosi each pass through 2 flops, plus a third flop for edge detection.
  - Leading edge = synced sclk transition away from CPOL; trailing edge = transition back to CPOL.
  - Edge events are internal single-clk pulses.
- Frame format:
  - Byte 0 = command: bit7 = R(1)/W(0), bits6:0 = start address.
  - Bytes 1..n = data.
  - Address auto-increments after each data byte and wraps 127→0.
- FSM:
  - IDLE: wait for synced n_cs falling. Then → CMD, clear bit counter and rx shift register.
  - CMD: shift mosi into rx shift register on each leading edge. On the 8th leading edge, latch rw and addr, then → DATA.
    - If read: in the same cycle, load tx shift register with reg[addr] (0x00 if unmapped) and drive its MSB on miso.
  - DATA, per byte: shift rx on leading edges, shift tx (next bit onto miso) on trailing edges.
    - On the 8th leading edge of a byte:
      - write with addr < N_REGS: reg[addr] ← rx byte and wr_strobe[addr] = 1 for exactly that cycle.
      - write with addr unmapped: byte ignored, no strobe.
      - read: tx reloads with reg[addr+1] (0x00 if unmapped) at the same point.
      - both: addr ← addr+1, bit counter ← 0, remain in DATA.
  - Any state, synced n_cs high: → IDLE next clk. Partial byte discarded, no write, miso = 0, bit counter cleared.
- miso during CMD and during write frames = 0.
- Timing:
  - Register update and strobe occur 4 clk after the 8th sampling sclk edge at the pin (2 sync + 1 detect + 1 register).
  - In read mode, miso changes ≤ 4 clk after the trailing edge. This is why sclk ≤ clk/8 is required.
- Simultaneous events:
  - n_cs rising in the same clk as the 8th leading edge: the byte completes (write/strobe occurs), then → IDLE.
  - A write to reg[k] and a read of reg[k] in one frame return the value at tx load time.
- Reads never alter registers.
- rst asserted mid-frame: immediate return to reset values. After rst release, a frame already in progress is ignored until n_cs goes high then low again.
- Glitches on sclk while n_cs high are ignored.

Test Plan:
- Write single: CPOL=0, frame 0x03,0xA5 → regs_bus[8*3+:8] = 0xA5, wr_strobe = 0x0008 for one clk 4 clk after the 16th rising sclk edge, other regs 0.
- Burst write + read-back: write 0x0E,0x11,0x22,0x33 → reg14 = 0x11, reg15 = 0x22, addr 16 unmapped (no strobe). Then read 0x8E,0x00,0x00,0x00 → miso bytes 0x11,0x22,0x00.
- Wrap: N_REGS=128, write 0x7F,0x5A,0xC3 → reg127 = 0x5A, reg0 = 0xC3.
- Abort: CMD 0x02 then 5 bits of data and n_cs high → reg2 unchanged, no strobe, busy falls, next frame 0x02,0x77 writes correctly.
- CPOL=1 at sclk = clk/8: read 0x80 after writing reg0 = 0x96 → miso returns 0x96, bits stable at every falling (sampling) edge.
- Async reset mid-frame after reg1 = 0xFF: pulse rst mid-byte → all regs 0x00, miso 0, FSM IDLE. The remainder of the interrupted frame produces no writes.
